// File: rtl/pipes.sv
// Shared pipeline definitions: fetch FSM states, stage indices and the
// bundled hazard control word for the default five-stage pipeline.
package pipes;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_DROP = 2'd2
    } fetch_state_t;

    localparam int F_IDX      = 0;
    localparam int D_IDX      = 1;
    localparam int EX_IDX_DEF = 2;

    typedef struct packed {
        logic [3:0] stall;
        logic [3:0] flush;
        logic       pc_hold;
        logic       pc_sel;
    } hazard_ctl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush controller: turns memory waits, load-use hazards and
// execute redirects into per-register hold/bubble vectors and a PC select.
module hazard_ctrl
    import pipes::*;
#(
    parameter int STAGES = 5,
    parameter int EX_IDX = 2,
    parameter int PC_W   = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ireq_valid,
    input  logic              iresp_data_ok,
    input  logic              dreq_valid,
    input  logic              dresp_data_ok,
    input  logic              ld_use,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [STAGES-2:0] stall,
    output logic [STAGES-2:0] flush,
    output logic              pc_hold,
    output logic              pc_sel,
    output logic [PC_W-1:0]   pc_target,
    output logic              drop_fetch,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int M_IDX = STAGES - 2;

    fetch_state_t    state_q;
    logic [PC_W-1:0] redirect_q;

    logic mem_busy;
    logic fetch_out;
    logic fetch_busy;
    logic [STAGES-2:0] stall_d;
    logic [STAGES-2:0] flush_d;

    assign mem_busy   = dreq_valid & ~dresp_data_ok;
    assign fetch_out  = (state_q != FS_IDLE);
    assign fetch_busy = (fetch_out & ~iresp_data_ok) |
                        ((state_q == FS_IDLE) & ireq_valid & ~iresp_data_ok);

    // Only one fetch is ever outstanding; a redirect during WAIT parks the
    // target in redirect_q until the stale response drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FS_IDLE;
            redirect_q <= '0;
        end else begin
            case (state_q)
                FS_IDLE: if (ireq_valid && !iresp_data_ok) state_q <= FS_WAIT;
                FS_WAIT: begin
                    if (iresp_data_ok) begin
                        state_q <= FS_IDLE;
                    end else if (redirect_valid && !mem_busy) begin
                        state_q    <= FS_DROP;
                        redirect_q <= redirect_pc;
                    end
                end
                FS_DROP: begin
                    if (iresp_data_ok) begin
                        state_q <= FS_IDLE;
                    end else if (redirect_valid && !mem_busy) begin
                        redirect_q <= redirect_pc;
                    end
                end
                default: state_q <= FS_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_d    = '0;
        flush_d    = '0;
        pc_hold    = 1'b0;
        pc_sel     = 1'b0;
        drop_fetch = 1'b0;
        pc_target  = '0;

        if (mem_busy) begin
            for (int i = 0; i < M_IDX; i++) stall_d[i] = 1'b1;
            flush_d[M_IDX] = 1'b1;
            pc_hold        = 1'b1;
        end else if (redirect_valid) begin
            for (int i = 0; i < EX_IDX; i++) flush_d[i] = 1'b1;
            // Bus address must stay stable until the in-flight fetch returns.
            if (fetch_out && !iresp_data_ok) pc_hold = 1'b1;
            else                             pc_sel  = 1'b1;
        end else if (ld_use) begin
            stall_d[F_IDX] = 1'b1;
            flush_d[D_IDX] = 1'b1;
            pc_hold        = 1'b1;
        end else if (fetch_busy) begin
            flush_d[F_IDX] = 1'b1;
            pc_hold        = 1'b1;
        end

        if (state_q == FS_DROP) begin
            flush_d[F_IDX] = 1'b1;
            if (iresp_data_ok) begin
                drop_fetch = 1'b1;
                pc_sel     = 1'b1;
                pc_target  = redirect_q;
            end
        end

        if (redirect_valid) pc_target = redirect_pc;

        stall = stall_d & ~flush_d;
        flush = flush_d;

        if (reset) begin
            stall      = '0;
            flush      = '1;
            pc_hold    = 1'b0;
            pc_sel     = 1'b0;
            drop_fetch = 1'b0;
            pc_target  = redirect_valid ? redirect_pc : '0;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (|stall),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: idle stream, memory wait, load-use,
// redirect during fetch, redirect masked by memory wait, reset mid-drop.
module tb_hazard_ctrl;
    import pipes::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid, iresp_data_ok, dreq_valid, dresp_data_ok;
    logic        ld_use, redirect_valid;
    logic [63:0] redirect_pc;
    logic [3:0]  stall, flush;
    logic        pc_hold, pc_sel, drop_fetch;
    logic [63:0] pc_target;
    logic [31:0] stall_cycles;

    logic        sc_rst, sc_inc;
    logic [1:0]  sc_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .iresp_data_ok(iresp_data_ok),
        .dreq_valid(dreq_valid), .dresp_data_ok(dresp_data_ok),
        .ld_use(ld_use), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall), .flush(flush), .pc_hold(pc_hold), .pc_sel(pc_sel),
        .pc_target(pc_target), .drop_fetch(drop_fetch), .stall_cycles(stall_cycles)
    );

    sat_counter #(.W(2)) u_sc (.clk(clk), .reset(sc_rst), .inc(sc_inc), .count(sc_cnt));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic [3:0] s, input logic [3:0] f,
                           input logic ph, input logic ps);
        chk({tag, ".stall"}, 64'(stall), 64'(s));
        chk({tag, ".flush"}, 64'(flush), 64'(f));
        chk({tag, ".pc_hold"}, 64'(pc_hold), 64'(ph));
        chk({tag, ".pc_sel"}, 64'(pc_sel), 64'(ps));
    endtask

    initial begin
        reset = 1'b1; sc_rst = 1'b1; sc_inc = 1'b0;
        ireq_valid = 0; iresp_data_ok = 0; dreq_valid = 0; dresp_data_ok = 0;
        ld_use = 0; redirect_valid = 0; redirect_pc = '0;
        tick(); tick();

        // Reset outputs; pc_target follows redirect_pc even in reset
        redirect_valid = 1; redirect_pc = 64'h123; #1;
        chk_ctl("rst", 4'b0000, 4'b1111, 0, 0);
        chk("rst.pc_target_redir", pc_target, 64'h123);
        redirect_valid = 0; #1;
        chk("rst.pc_target", pc_target, 64'h0);
        reset = 0; sc_rst = 0;
        tick();
        chk("rst.state", 64'(dut.state_q), 64'(FS_IDLE));
        chk("rst.cnt", 64'(stall_cycles), 64'd0);

        // Idle stream
        ireq_valid = 1; iresp_data_ok = 1;
        for (int i = 0; i < 10; i++) tick();
        chk_ctl("idle", 4'b0000, 4'b0000, 0, 0);
        chk("idle.cnt", 64'(stall_cycles), 64'd0);

        // Memory wait: two stalled cycles, response in the third
        dreq_valid = 1; dresp_data_ok = 0; #1;
        chk_ctl("mem1", 4'b0111, 4'b1000, 1, 0);
        tick(); #1;
        chk_ctl("mem2", 4'b0111, 4'b1000, 1, 0);
        tick();
        dresp_data_ok = 1; #1;
        chk_ctl("mem3", 4'b0000, 4'b0000, 0, 0);
        tick();
        dreq_valid = 0; dresp_data_ok = 0; #1;
        chk("mem.cnt", 64'(stall_cycles), 64'd2);

        // Load-use for one cycle
        ld_use = 1; #1;
        chk_ctl("lduse", 4'b0001, 4'b0010, 1, 0);
        tick();
        ld_use = 0; #1;
        chk_ctl("lduse.after", 4'b0000, 4'b0000, 0, 0);
        chk("lduse.cnt", 64'(stall_cycles), 64'd3);

        // Fetch outstanding, then redirect while waiting
        iresp_data_ok = 0; #1;
        chk_ctl("fetch.idle_busy", 4'b0000, 4'b0001, 1, 0);
        tick();
        chk("fetch.state_wait", 64'(dut.state_q), 64'(FS_WAIT));
        redirect_valid = 1; redirect_pc = 64'h8000_0100; #1;
        chk_ctl("redir.wait", 4'b0000, 4'b0011, 1, 0);
        tick();
        redirect_valid = 0; redirect_pc = '0; #1;
        chk("redir.state_drop", 64'(dut.state_q), 64'(FS_DROP));
        chk_ctl("drop.wait", 4'b0000, 4'b0001, 1, 0);
        chk("drop.wait.drop_fetch", 64'(drop_fetch), 64'd0);
        tick();
        iresp_data_ok = 1; #1;
        chk("drop.resp.drop_fetch", 64'(drop_fetch), 64'd1);
        chk("drop.resp.pc_sel", 64'(pc_sel), 64'd1);
        chk("drop.resp.pc_target", pc_target, 64'h8000_0100);
        tick();
        chk("drop.state_idle", 64'(dut.state_q), 64'(FS_IDLE));
        chk("drop.idle.drop_fetch", 64'(drop_fetch), 64'd0);

        // Redirect masked by memory wait while in WAIT
        iresp_data_ok = 0; tick();
        dreq_valid = 1; dresp_data_ok = 0;
        redirect_valid = 1; redirect_pc = 64'hdead_0000; #1;
        chk_ctl("redir_mem", 4'b0111, 4'b1000, 1, 0);
        chk("redir_mem.pc_target", pc_target, 64'hdead_0000);
        tick();
        chk("redir_mem.state_wait", 64'(dut.state_q), 64'(FS_WAIT));
        chk("redir_mem.cnt", 64'(stall_cycles), 64'd4);

        // Redirect unmasked with response arriving same cycle: direct pc_sel
        dreq_valid = 0; iresp_data_ok = 1; redirect_pc = 64'h4000; #1;
        chk_ctl("redir_resp", 4'b0000, 4'b0011, 0, 1);
        tick();
        chk("redir_resp.state", 64'(dut.state_q), 64'(FS_IDLE));

        // Reset asserted mid-drop
        redirect_valid = 0; iresp_data_ok = 0; tick();
        redirect_valid = 1; redirect_pc = 64'h5000; tick();
        redirect_valid = 0;
        chk("rdrop.state_drop", 64'(dut.state_q), 64'(FS_DROP));
        reset = 1; iresp_data_ok = 1; #1;
        chk_ctl("rdrop.rst", 4'b0000, 4'b1111, 0, 0);
        chk("rdrop.drop_fetch", 64'(drop_fetch), 64'd0);
        chk("rdrop.pc_target", pc_target, 64'h0);
        tick();
        reset = 0; iresp_data_ok = 1; #1;
        chk("rdrop.state_idle", 64'(dut.state_q), 64'(FS_IDLE));
        chk("rdrop.cnt", 64'(stall_cycles), 64'd0);
        chk_ctl("rdrop.after", 4'b0000, 4'b0000, 0, 0);

        // Saturation on a narrow counter
        sc_inc = 1;
        tick(); tick(); tick();
        chk("sat.at3", 64'(sc_cnt), 64'd3);
        tick(); tick();
        chk("sat.hold", 64'(sc_cnt), 64'd3);
        sc_inc = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central stall/flush controller for the parametrised in-order pipeline. It turns bus wait conditions, load-use hazards and execute-stage redirects into per-register hold/bubble vectors and a PC-select. It also tracks one outstanding instruction fetch so that a redirect arriving mid-fetch discards the stale instruction. It sits beside the stage registers in `core`, replacing the free-running pipeline.

## Interface
- `STAGES`, default 5: pipeline stages (F=0, D=1, E=2, …, M=`STAGES`-2, W=`STAGES`-1); stage registers are indexed 0..`STAGES`-2, where register i sits after stage i.
- `EX_IDX`, default 2: stage that resolves branches/jumps.
- `PC_W`, default 64: PC width.
- `CNT_W`, default 32: stall counter width.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `ireq_valid` in 1: fetch is presenting an instruction request this cycle.
- `iresp_data_ok` in 1: instruction data returned this cycle.
- `dreq_valid` in 1: memory stage has a data request active.
- `dresp_data_ok` in 1: data response returned this cycle.
- `ld_use` in 1: the instruction in D reads the destination of a load in E.
- `redirect_valid` in 1: the instruction in `EX_IDX` redirects the PC.
- `redirect_pc` in `PC_W`: redirect target.
- `stall` out `STAGES`-1: bit i holds stage register i.
- `flush` out `STAGES`-1: bit i loads a bubble (valid=0, all control 0) into register i.
- `pc_hold` out 1: PC register keeps its value.
- `pc_sel` out 1: PC loads `pc_target` instead of pc+4.
- `pc_target` out `PC_W`: redirect target.
- `drop_fetch` out 1: the current `iresp` is stale and must not enter freg.
- `stall_cycles` out `CNT_W`: saturating count of cycles with any `stall` bit set.

## Operation
- Define `mem_busy` = `dreq_valid` & ~`dresp_data_ok`.
- Define `fetch_busy` = (state WAIT or DROP) & ~`iresp_data_ok`, or state IDLE & `ireq_valid` & ~`iresp_data_ok`.
- Fetch FSM `fetch_state_t` has states IDLE, WAIT and DROP.
  - IDLE → WAIT on `ireq_valid` & ~`iresp_data_ok`.
  - WAIT → IDLE on `iresp_data_ok`.
  - WAIT → DROP on `redirect_valid` & ~`mem_busy` & ~`iresp_data_ok`. On this transition `redirect_q` ← `redirect_pc`.
  - DROP → IDLE on `iresp_data_ok`.
- Conditions are resolved in this priority order; a condition masked by a higher one takes no effect in that cycle.
- 1. `mem_busy`:
  - `stall`[0..M-1] = 1 and `flush`[M] = 1; `pc_hold` = 1.
  - `ld_use` and `redirect_valid` are ignored. Their sources are frozen, so they re-assert when the condition clears.
  - The FSM still tracks `iresp_data_ok`. A response arriving while `stall`[0] = 1 is held by the fetch unit, not by this block.
- 2. `redirect_valid`:
  - `flush`[0..`EX_IDX`-1] = 1.
  - If no fetch is outstanding, or `iresp_data_ok` = 1 this cycle: `pc_sel` = 1 and `pc_target` = `redirect_pc`.
  - Otherwise: `pc_hold` = 1 (the bus address must stay stable) and the FSM enters DROP.
  - `ld_use` is ignored.
- 3. `ld_use`: `stall`[0] = 1, `flush`[1] = 1, `pc_hold` = 1.
- 4. `fetch_busy`: `flush`[0] = 1, `pc_hold` = 1.
- In DROP:
  - `flush`[0] = 1 every cycle.
  - On `iresp_data_ok`: `drop_fetch` = 1, `pc_sel` = 1, `pc_target` = `redirect_q`.
  - A further `redirect_valid` in DROP overwrites `redirect_q`.
- `flush` takes precedence over `stall` on the same bit.
- `stall_cycles` increments by 1 in any cycle where |`stall` is true, and holds at all-ones.

## Timing
- All outputs are combinational from the inputs and the registered state, with zero-cycle latency. State, `redirect_q` and the counter are registered on `posedge clk`.
- While `reset` is high:
  - Outputs: `stall` = 0, `flush` = all-ones, `pc_hold` = 0, `pc_sel` = 0, `drop_fetch` = 0.
  - `pc_target`: 0 in general; it equals `redirect_pc` whenever `redirect_valid` is high, in reset or not.
- On the next edge after reset: state ← IDLE, `redirect_q` ← 0, `stall_cycles` ← 0.
- Reset mid-DROP abandons the drop. The bus is reset with the core.
- Redirect penalty: `EX_IDX` bubbles, plus the remaining fetch latency when the redirect lands in WAIT.

## Structure
- Package `pipes` holds:
  - `fetch_state_t` enum;
  - stage index constants `F_IDX`, `D_IDX`, `EX_IDX_DEF`;
  - `hazard_ctl_t` struct bundling `stall`, `flush`, `pc_hold` and `pc_sel` for the default 5 stages.
- Sub-module `sat_counter` (params `W`; ports `clk`, `reset`, `inc`, `count`) implements `stall_cycles`.

## Test plan
- Idle stream: `ireq_valid` = 1 and `iresp_data_ok` = 1 every cycle. Expect `stall` = 0, `flush` = 0 and `stall_cycles` = 0 after 10 cycles.
- `dreq_valid` = 1 for 3 cycles with `dresp_data_ok` only in the 3rd:
  - cycles 1–2: `stall` = 4'b0111, `flush` = 4'b1000, `pc_hold` = 1;
  - cycle 3: `stall` = 4'b0000;
  - `stall_cycles` = 2.
- `ld_use` = 1 for one cycle. Expect `stall` = 4'b0001, `flush` = 4'b0010, `pc_hold` = 1; next cycle all 0.
- In WAIT with no `iresp_data_ok`, apply `redirect_valid` with `redirect_pc` = 64'h8000_0100:
  - that cycle: `flush` = 4'b0011, `pc_hold` = 1;
  - next cycle: state DROP;
  - 2 cycles later, `iresp_data_ok`: `drop_fetch` = 1, `pc_sel` = 1, `pc_target` = 64'h8000_0100, state IDLE.
- `redirect_valid` and `mem_busy` asserted together: `pc_sel` = 0, `flush` = 4'b1000, and state stays WAIT.
- Reset asserted while in DROP: `flush` = 4'b1111, `drop_fetch` = 0; after release, state IDLE and `stall_cycles` = 0.
